// File: rtl/bus_pkg.sv
// Shared bus definitions: master-port state encoding, device-select codes and
// the default field widths used by the arbiter, slave ports and master port.
package bus_pkg;

   localparam int BUS_DEV_ADDR_W = 4;
   localparam int BUS_MEM_ADDR_W = 12;
   localparam int BUS_DATA_W     = 16;

   localparam logic [3:0] DEV_S1     = 4'b0000;
   localparam logic [3:0] DEV_S2     = 4'b0001;
   localparam logic [3:0] DEV_S3     = 4'b0010;
   localparam logic [1:0] DEV_BB_PFX = 2'b11;

   typedef enum logic [2:0] {
      MP_IDLE     = 3'd0,
      MP_DEV_ADDR = 3'd1,
      MP_ACK_CHK  = 3'd2,
      MP_MEM_ADDR = 3'd3,
      MP_WDATA    = 3'd4,
      MP_RDATA    = 3'd5,
      MP_DONE     = 3'd6
   } mp_state_e;

   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// MSB-first shift register with parallel load, shift enable and transfer counter.
// The top TAP_W bits are exposed: 1 for a serialiser, W for a deserialiser.
module serial_shift_reg #(
   parameter int W     = 16,
   parameter int CW    = 5,
   parameter int TAP_W = W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_i,
   input  logic [W-1:0]     load_data_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [TAP_W-1:0] tap_o,
   output logic [CW-1:0]    cnt_o
);

   logic [W-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A load starts a new field, so it wins over a shift in the same cycle.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = load_data_i;
         cnt_d   = '0;
      end else if (shift_i) begin
         shreg_d = {shreg_q[W-2:0], ser_i};
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign tap_o = shreg_q[W-1 -: TAP_W];
   assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_master_port.sv
// Serial master port feeding arbiter port 1: serialises dev/mem/data fields MSB-first.
// Optional watchdog on stalled handshakes is enabled with `define MASTER_PORT_TIMEOUT_EN.
module bus_master_port
   import bus_pkg::*;
#(
   parameter int DEV_ADDR_WIDTH = BUS_DEV_ADDR_W,
   parameter int MEM_ADDR_WIDTH = BUS_MEM_ADDR_W,
   parameter int DATA_WIDTH     = BUS_DATA_W,
   parameter int TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_mode,
   input  logic [DEV_ADDR_WIDTH-1:0] req_dev,
   input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      rsp_valid,
   output logic                      rsp_err,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      mode,
   output logic                      wr_bus,
   output logic                      master_valid,
   input  logic                      slave_ready,
   output logic                      master_ready,
   input  logic                      slave_valid,
   input  logic                      rd_bus,
   input  logic                      ack
);

   localparam int FW = max_of3(DEV_ADDR_WIDTH, MEM_ADDR_WIDTH, DATA_WIDTH);
   localparam int CW = $clog2(FW) + 1;

   localparam logic [CW-1:0] DEV_LAST  = CW'(DEV_ADDR_WIDTH - 1);
   localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_ADDR_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

   // Fields are left-justified in the tx register so the MSB always leaves first.
   function automatic logic [FW-1:0] align_msb(input logic [FW-1:0] v, input int width);
      return v << (FW - width);
   endfunction

   mp_state_e state_q, state_d;
   logic                      rdy_q, rdy_d;
   logic                      mode_q, mode_d;
   logic                      err_q, err_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

   logic            tx_load;
   logic [FW-1:0]   tx_load_data;
   logic            tx_msb;
   logic [CW-1:0]   tx_cnt;
   logic            rx_load;
   logic [DATA_WIDTH-1:0] rx_par;
   logic [CW-1:0]   rx_cnt;

   logic mv, mr, xfer_out, xfer_in, wdog_hit;

   assign mv       = (state_q == MP_DEV_ADDR) || (state_q == MP_MEM_ADDR) || (state_q == MP_WDATA);
   assign mr       = (state_q == MP_RDATA);
   assign xfer_out = mv && slave_ready;
   assign xfer_in  = mr && slave_valid;

   serial_shift_reg #(
      .W     (FW),
      .CW    (CW),
      .TAP_W (1)
   ) u_tx (
      .clk         (clk),
      .rstn        (rstn),
      .load_i      (tx_load),
      .load_data_i (tx_load_data),
      .shift_i     (xfer_out),
      .ser_i       (1'b0),
      .tap_o       (tx_msb),
      .cnt_o       (tx_cnt)
   );

   serial_shift_reg #(
      .W     (DATA_WIDTH),
      .CW    (CW),
      .TAP_W (DATA_WIDTH)
   ) u_rx (
      .clk         (clk),
      .rstn        (rstn),
      .load_i      (rx_load),
      .load_data_i ('0),
      .shift_i     (xfer_in),
      .ser_i       (rd_bus),
      .tap_o       (rx_par),
      .cnt_o       (rx_cnt)
   );

`ifdef MASTER_PORT_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wdog_q, wdog_d;

   assign wdog_hit = (mv || mr) && !(xfer_out || xfer_in) && (wdog_q >= WW'(TIMEOUT));

   // Any progress, or leaving the state, restarts the wait window.
   always_comb begin
      wdog_d = wdog_q;
      if (xfer_out || xfer_in || (state_d != state_q)) begin
         wdog_d = '0;
      end else if (wdog_q != WW'(TIMEOUT)) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign wdog_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      err_d        = err_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      tx_load      = 1'b0;
      tx_load_data = '0;
      rx_load      = 1'b0;

      unique case (state_q)
         MP_IDLE: begin
            if (rdy_q && req_valid) begin
               tx_load      = 1'b1;
               tx_load_data = align_msb(FW'(req_dev), DEV_ADDR_WIDTH);
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               mode_d       = req_mode;
               err_d        = 1'b0;
               state_d      = MP_DEV_ADDR;
            end
         end
         MP_DEV_ADDR: begin
            if (xfer_out && (tx_cnt == DEV_LAST)) begin
               state_d = MP_ACK_CHK;
            end
         end
         MP_ACK_CHK: begin
            if (ack) begin
               tx_load      = 1'b1;
               tx_load_data = align_msb(FW'(addr_q), MEM_ADDR_WIDTH);
               state_d      = MP_MEM_ADDR;
            end else begin
               err_d   = 1'b1;
               state_d = MP_DONE;
            end
         end
         MP_MEM_ADDR: begin
            if (xfer_out && (tx_cnt == MEM_LAST)) begin
               if (mode_q) begin
                  tx_load      = 1'b1;
                  tx_load_data = align_msb(FW'(wdata_q), DATA_WIDTH);
                  state_d      = MP_WDATA;
               end else begin
                  rx_load = 1'b1;
                  state_d = MP_RDATA;
               end
            end
         end
         MP_WDATA: begin
            if (xfer_out && (tx_cnt == DATA_LAST)) begin
               state_d = MP_DONE;
            end
         end
         MP_RDATA: begin
            // The last bit is still on rd_bus, so fold it in directly.
            if (xfer_in && (rx_cnt == DATA_LAST)) begin
               rdata_d = {rx_par[DATA_WIDTH-2:0], rd_bus};
               state_d = MP_DONE;
            end
         end
         MP_DONE: begin
            mode_d  = 1'b0;
            err_d   = 1'b0;
            state_d = MP_IDLE;
         end
         default: begin
            state_d = MP_IDLE;
         end
      endcase

      if (wdog_hit) begin
         tx_load = 1'b0;
         rx_load = 1'b0;
         err_d   = 1'b1;
         state_d = MP_DONE;
      end

      rdy_d = (state_d == MP_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= MP_IDLE;
         rdy_q   <= 1'b0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign req_ready    = rdy_q;
   assign rsp_valid    = (state_q == MP_DONE);
   assign rsp_err      = err_q;
   assign rsp_rdata    = rdata_q;
   assign mode         = mode_q;
   assign master_valid = mv;
   assign master_ready = mr;
   assign wr_bus       = mv & tx_msb;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: table-driven frames, randomized frames
// against a bit-stream reference model, plus reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_bus_master_port;

   localparam int VW = 4;
   localparam int MW = 12;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid, req_mode;
   logic [VW-1:0] req_dev;
   logic [MW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_ready, rsp_valid, rsp_err, mode, wr_bus, master_valid, master_ready;
   logic [DW-1:0] rsp_rdata;
   logic          slave_ready, slave_valid, rd_bus, ack;

   always #5 clk = ~clk;

   bus_master_port dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_mode     (req_mode),
      .req_dev      (req_dev),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .mode         (mode),
      .wr_bus       (wr_bus),
      .master_valid (master_valid),
      .slave_ready  (slave_ready),
      .master_ready (master_ready),
      .slave_valid  (slave_valid),
      .rd_bus       (rd_bus),
      .ack          (ack)
   );

   typedef struct {
      bit            mode;
      logic [VW-1:0] dev;
      logic [MW-1:0] addr;
      logic [DW-1:0] wdata;
      bit            ackv;
      logic [DW-1:0] sword;
      int            rdy_pat;  // 0 always ready, 1 random, 2 ten-cycle stall mid-address
      int            vld_pat;  // 0 always valid, 1 toggling 1/0, 2 random
      int            exp_lat;  // -1 when the handshake pattern makes it data dependent
   } vec_t;

   typedef struct {
      logic [63:0]   bits;
      int            nbits;
      int            lat;
      bit            err;
      logic [DW-1:0] rdata;
      int            caps;
      bit            frame_ok;
      bit            stall_ok;
      bit            post_ok;
   } res_t;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] model_rdata = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the frame is the device field, then (only on ack) the address
   // field, then (writes only) the data field, each sent MSB-first.
   function automatic void build_exp(input vec_t v, output logic [63:0] vec, output int n);
      vec = '0;
      n   = 0;
      for (int i = VW - 1; i >= 0; i--) begin vec = {vec[62:0], v.dev[i]};   n++; end
      if (v.ackv) begin
         for (int i = MW - 1; i >= 0; i--) begin vec = {vec[62:0], v.addr[i]}; n++; end
         if (v.mode) begin
            for (int i = DW - 1; i >= 0; i--) begin vec = {vec[62:0], v.wdata[i]}; n++; end
         end
      end
   endfunction

   // Called at the start of cycle 1 (just after the accept edge); ends in the IDLE cycle.
   task automatic drain(input vec_t v, output res_t r);
      int   si, stall_n;
      logic held;
      r.bits = '0; r.nbits = 0; r.lat = -1; r.err = 1'b0; r.rdata = '0; r.caps = 0;
      r.frame_ok = 1'b1; r.stall_ok = 1'b1; r.post_ok = 1'b0;
      si = 0; stall_n = 0; held = 1'b0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         case (v.rdy_pat)
            1: slave_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (r.nbits == 10 && stall_n < 10) begin
                  slave_ready = 1'b0;
                  if (stall_n == 0) held = wr_bus;
                  if (wr_bus !== held || master_valid !== 1'b1) r.stall_ok = 1'b0;
                  stall_n++;
               end else begin
                  slave_ready = 1'b1;
               end
            end
            default: slave_ready = 1'b1;
         endcase
         case (v.vld_pat)
            1:       slave_valid = (cyc % 2 == 1);
            2:       slave_valid = ($urandom_range(0, 2) != 0);
            default: slave_valid = 1'b1;
         endcase
         rd_bus = (si < DW) ? v.sword[DW-1-si] : 1'b0;
         if (req_ready !== 1'b0 || mode !== v.mode) r.frame_ok = 1'b0;
         if (master_valid && slave_ready) begin
            r.bits = {r.bits[62:0], wr_bus};
            r.nbits++;
         end
         if (master_ready && slave_valid) begin
            r.caps++;
            si++;
         end
         if (rsp_valid) begin
            r.lat   = cyc;
            r.err   = rsp_err;
            r.rdata = rsp_rdata;
            break;
         end
         tick();
      end
      if (v.rdy_pat == 2 && stall_n != 10) r.stall_ok = 1'b0;
      tick();
      r.post_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (mode === 1'b0) &&
                  (rsp_err === 1'b0) && (master_valid === 1'b0) && (master_ready === 1'b0);
   endtask

   task automatic check_txn(input string tag, input vec_t v, input res_t r);
      logic [63:0] exp_bits;
      int          exp_n;
      build_exp(v, exp_bits, exp_n);
      if (v.ackv && !v.mode) model_rdata = v.sword;
      check({tag, "_complete"}, 64'(r.lat >= 0), 64'(1));
      check({tag, "_bits"},     r.bits, exp_bits);
      check({tag, "_nbits"},    64'(r.nbits), 64'(exp_n));
      check({tag, "_err"},      64'(r.err), 64'(!v.ackv));
      check({tag, "_rdata"},    64'(r.rdata), 64'(model_rdata));
      check({tag, "_captures"}, 64'(r.caps), 64'((v.ackv && !v.mode) ? DW : 0));
      check({tag, "_frame"},    64'(r.frame_ok), 64'(1));
      check({tag, "_post_idle"}, 64'(r.post_ok), 64'(1));
      if (v.exp_lat >= 0) check({tag, "_latency"}, 64'(r.lat), 64'(v.exp_lat));
      if (v.rdy_pat == 2) check({tag, "_stall_hold"}, 64'(r.stall_ok), 64'(1));
   endtask

   task automatic run_txn(input string tag, input vec_t v);
      res_t r;
      req_mode  = v.mode;
      req_dev   = v.dev;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      ack       = v.ackv;
      req_valid = 1'b1;
      check({tag, "_req_ready"}, 64'(req_ready), 64'(1));
      tick();
      req_valid = 1'b0;
      req_mode  = 1'($urandom);
      req_dev   = VW'($urandom);
      req_addr  = MW'($urandom);
      req_wdata = DW'($urandom);
      drain(v, r);
      check_txn(tag, v, r);
   endtask

   vec_t tbl[7];

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t v, va, vb;
      res_t r;

      tbl[0] = '{1'b1, 4'b0001, 12'h0A5, 16'hBEEF, 1'b1, 16'h0000, 0, 0, 34};
      tbl[1] = '{1'b0, 4'b0000, 12'h123, 16'h0000, 1'b1, 16'h5A3C, 0, 1, -1};
      tbl[2] = '{1'b1, 4'b0111, 12'hFFF, 16'h1234, 1'b0, 16'h0000, 0, 0, 6};
      tbl[3] = '{1'b0, 4'b0111, 12'h3C3, 16'h0000, 1'b0, 16'hFFFF, 0, 0, 6};
      tbl[4] = '{1'b1, 4'b0010, 12'h5A5, 16'hC3A1, 1'b1, 16'h0000, 2, 0, 44};
      tbl[5] = '{1'b0, 4'b0010, 12'hFFF, 16'h0000, 1'b1, 16'h8001, 0, 0, 34};
      tbl[6] = '{1'b1, 4'b1100, 12'h000, 16'h0000, 1'b1, 16'h0000, 0, 0, 34};

      rstn = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_dev = '0; req_addr = '0;
      req_wdata = '0; slave_ready = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0; ack = 1'b0;
      #2;
      check("reset_outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, mode,
                                 wr_bus, master_valid, master_ready}), 64'(0));
      tick(); tick();
      check("reset_held_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      rstn = 1'b1;
      tick();
      check("idle_ready", 64'(req_ready), 64'(1));

      for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

      for (int i = 0; i < 20; i++) begin
         v.mode    = 1'($urandom);
         v.dev     = VW'($urandom);
         v.addr    = MW'($urandom);
         v.wdata   = DW'($urandom);
         v.ackv    = ($urandom_range(0, 4) != 0);
         v.sword   = DW'($urandom);
         v.rdy_pat = 1;
         v.vld_pat = 2;
         v.exp_lat = -1;
         run_txn($sformatf("rand%0d", i), v);
      end

      // Asynchronous reset in the middle of a write frame.
      req_mode = 1'b1; req_dev = 4'b0001; req_addr = 12'h3C3; req_wdata = 16'hA55A;
      ack = 1'b1; slave_ready = 1'b1; slave_valid = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      check("pre_reset_busy", 64'(master_valid), 64'(1));
      rstn = 1'b0;
      #1;
      check("async_reset_outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, mode,
                                       wr_bus, master_valid, master_ready}), 64'(0));
      model_rdata = '0;
      @(negedge clk);
      rstn = 1'b1;
      tick();
      run_txn("after_reset", tbl[0]);

      // Back-to-back: req_valid stays high across both requests.
      va = '{1'b1, 4'b0010, 12'h111, 16'h1234, 1'b1, 16'h0000, 0, 0, 34};
      vb = '{1'b0, 4'b0001, 12'h222, 16'h0000, 1'b1, 16'h0F0F, 0, 0, 34};
      req_mode = va.mode; req_dev = va.dev; req_addr = va.addr; req_wdata = va.wdata;
      ack = 1'b1; req_valid = 1'b1;
      check("b2b_a_ready", 64'(req_ready), 64'(1));
      tick();
      req_mode = vb.mode; req_dev = vb.dev; req_addr = vb.addr; req_wdata = vb.wdata;
      drain(va, r);
      check_txn("b2b_a", va, r);
      tick();
      req_valid = 1'b0;
      drain(vb, r);
      check_txn("b2b_b", vb, r);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Serial master interface that sits directly upstream of the bus arbiter and drives its master-1 port.
- Accepts one parallel read/write request from a local requester and serialises it MSB-first onto the 1-bit wr_bus: device address, then memory address, then write data.
- Waits for the arbiter's ack after the device address. For reads, deserialises the returned rd_bus bits and returns a parallel response with error status.

Parameters:
DEV_ADDR_WIDTH, 4, device-select bits sent first (decoded by arbiter)
MEM_ADDR_WIDTH, 12, in-slave address bits sent after ack
DATA_WIDTH, 16, read/write data bits
TIMEOUT, 255, max wait cycles per handshake (used only with MASTER_PORT_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle
req_mode  in  1  1=write, 0=read
req_dev  in  DEV_ADDR_WIDTH  device address
req_addr  in  MEM_ADDR_WIDTH  memory address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  1 = no ack (or timeout); valid with rsp_valid
rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads
mode  out  1  to arbiter m1_mode; held for whole frame
wr_bus  out  1  serial out bit
master_valid  out  1  wr_bus bit valid
slave_ready  in  1  arbiter/slave accepts bit
master_ready  out  1  ready for read bit
slave_valid  in  1  rd_bus bit valid
rd_bus  in  1  serial read bit
ack  in  1  slave-selected acknowledge from arbiter

Behaviour:
- Reset values (async, rstn low): all outputs 0, state IDLE, counters and shift registers 0. Reset mid-frame aborts immediately with no response.
- Bit transfer out: occurs on a clk edge where master_valid && slave_ready. Bit transfer in: occurs on an edge where master_ready && slave_valid.
- State machine (states in package enum):
  - IDLE: req_ready=1. On req_valid, latch all req_* fields, set mode=req_mode, go to DEV_ADDR. Request accept costs 1 cycle.
  - DEV_ADDR: master_valid=1, wr_bus=current MSB of device field. Shift on each transfer. After DEV_ADDR_WIDTH transfers, go to ACK_CHK.
  - ACK_CHK: master_valid=0; sample ack for exactly one cycle. If ack=1, go to MEM_ADDR. If ack=0, set rsp_err=1 and go to DONE.
  - MEM_ADDR: MEM_ADDR_WIDTH bits, same rules as DEV_ADDR. Next state is WDATA if mode=1, else RDATA.
  - WDATA: DATA_WIDTH bits out, then DONE.
  - RDATA: master_valid=0, master_ready=1. Shift rd_bus into LSB on each transfer. After DATA_WIDTH transfers, go to DONE.
  - DONE: rsp_valid=1 for one cycle, then IDLE. mode returns to 0 and rsp_err clears on the IDLE entry.
- Bit counter width is clog2(max field width)+1. The counter resets to 0 at each field boundary.
- slave_ready low stalls the current bit indefinitely (without the optional feature). wr_bus must stay stable while master_valid=1 and slave_ready=0.
- req_valid is ignored outside IDLE; at most one request is in flight.
- rsp_rdata holds its last read value until the next read completes. On writes and errors it is unchanged.
- Ideal-slave write latency: 1 + DEV + 1 + MEM + DATA cycles from accept to rsp_valid.

Optional Feature:
- Macro: MASTER_PORT_TIMEOUT_EN.
- Defined: a watchdog counter resets on every bit transfer and on each state change. If it reaches TIMEOUT while in DEV_ADDR/MEM_ADDR/WDATA/RDATA, the block drops master_valid/master_ready, sets rsp_err=1 and goes to DONE.
- Undefined: no watchdog logic; stalls last forever.

Decomposition:
- Shared package bus_pkg:
  - master port state enum.
  - Device address constants: DEV_S1=4'b0000, DEV_S2=4'b0001, DEV_S3=4'b0010, DEV_BB prefix 2'b11.
  - Default width localparams, shared with the arbiter and slave ports.
- One natural sub-module: serial_shift_reg, a parameterised MSB-first PISO/SIPO with load, shift-enable and bit counter. Instantiated once for tx, once for rx.

Test Plan:
- Write, ideal slave (slave_ready=1, ack=1): dev=0001, addr=0x0A5, wdata=0xBEEF, accepted cycle 0. Required: wr_bus bits 0001 in cycles 1-4, ACK_CHK in 5, 0x0A5 in 6-17, 0xBEEF in 18-33, rsp_valid=1/rsp_err=0 in cycle 34.
- Read from dev=0000, addr=0x123; slave returns 0x5A3C with slave_valid toggling 1/0. Required: rsp_rdata=0x5A3C, rsp_err=0, exactly 16 captures.
- No ack: dev=0111, ack=0. Required: no MEM_ADDR bits, rsp_valid with rsp_err=1 at cycle 6, back to IDLE at cycle 7.
- Stall: slave_ready=0 for 10 cycles mid-MEM_ADDR. Required: wr_bus stable and master_valid held; frame completes correctly; with MASTER_PORT_TIMEOUT_EN and TIMEOUT=8, rsp_err=1 instead.
- Async reset asserted at cycle 20 of a write. Required: all outputs 0 immediately; next request after release completes normally.
- Back-to-back: req_valid held high across two requests. Required: second accepted only in the IDLE cycle after DONE; req_valid ignored mid-frame.
